upg_boot_ctrl: RTL and testbench

Programming-mode controller that sequences the UART bootloader and the CPU core. It arbitrates ownership of instruction and data memory between the running CPU and the UART loader. It replaces the ad-hoc start_pg/upg_rst latch at the top level and drives the CPU reset and UART reset. It steers loader writes to instruction or data memory by address bit 14, and reports load progress, timeouts and state for LED display.

---
 rtl/upg_boot_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_upg_boot_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/upg_boot_ctrl.sv
// Programming-mode controller: arbitrates memory ownership between the CPU and the UART
// loader, sequences both resets, and reports load progress and status for LED display.
module upg_boot_ctrl #(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int RUN_RST_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_pg,
  input  logic        upg_wen_i,
  input  logic [14:0] upg_adr_i,
  input  logic        upg_done_i,
  output logic        upg_rst_o,
  output logic        cpu_rst_o,
  output logic        imem_wen_o,
  output logic        dmem_wen_o,
  output logic [13:0] imem_words_o,
  output logic [13:0] dmem_words_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_ARM     = 3'd1,
    S_LOAD    = 3'd2,
    S_RELEASE = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(RUN_RST_CYCLES) + 1;

  localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RUN_RST_LAST = RW'(RUN_RST_CYCLES - 1);
  localparam logic [13:0]   WORDS_MAX    = '1;

  state_t        r_state;
  logic          r_spg_meta;
  logic          r_spg_s;
  logic          r_origin_err;
  logic          r_first;
  logic [HW-1:0] r_hold_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [RW-1:0] r_rel_cnt;
  logic [13:0]   r_imem_words;
  logic [13:0]   r_dmem_words;
  logic          r_upg_rst;
  logic          r_cpu_rst;
  logic          r_busy;
  logic          r_err;
  logic          w_in_load;
  logic          w_unused_adr;

  // Only the select bit of the address matters here; the word address goes straight to memory.
  assign w_unused_adr = ^upg_adr_i[13:0];

  // Write gating must stay combinational so the loader's strobe reaches memory in the same cycle.
  assign w_in_load  = (r_state == S_LOAD) & ~reset;
  assign imem_wen_o = w_in_load & upg_wen_i & ~upg_adr_i[14];
  assign dmem_wen_o = w_in_load & upg_wen_i &  upg_adr_i[14];

  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_RELEASE;
      r_spg_meta   <= 1'b0;
      r_spg_s      <= 1'b0;
      r_origin_err <= 1'b0;
      r_first      <= 1'b0;
      r_hold_cnt   <= '0;
      r_to_cnt     <= '0;
      r_rel_cnt    <= '0;
      r_imem_words <= '0;
      r_dmem_words <= '0;
      r_upg_rst    <= 1'b1;
      r_cpu_rst    <= 1'b1;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_spg_meta <= start_pg;
      r_spg_s    <= r_spg_meta;

      case (r_state)
        S_RUN: begin
          if (r_spg_s) begin
            r_state      <= S_ARM;
            r_origin_err <= 1'b0;
            r_hold_cnt   <= '0;
          end
        end

        // Outputs are left untouched in ARM, so they keep showing the origin state.
        S_ARM: begin
          if (!r_spg_s) begin
            r_state <= r_origin_err ? S_ERROR : S_RUN;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state      <= S_LOAD;
            r_first      <= 1'b1;
            r_to_cnt     <= '0;
            r_imem_words <= '0;
            r_dmem_words <= '0;
            r_upg_rst    <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_busy       <= 1'b1;
            r_err        <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end

        S_LOAD: begin
          r_first <= 1'b0;
          if (upg_wen_i) begin
            r_to_cnt <= '0;
            if (upg_adr_i[14]) begin
              if (r_dmem_words != WORDS_MAX) r_dmem_words <= r_dmem_words + 14'd1;
            end else begin
              if (r_imem_words != WORDS_MAX) r_imem_words <= r_imem_words + 14'd1;
            end
          end else if (r_to_cnt != TIMEOUT_LAST) begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end

          // Done is checked first so it wins over a coincident timeout.
          if (upg_done_i && !r_first) begin
            r_state   <= S_RELEASE;
            r_rel_cnt <= '0;
            r_upg_rst <= 1'b1;
            r_busy    <= 1'b0;
          end else if (!upg_wen_i && r_to_cnt == TIMEOUT_LAST) begin
            r_state   <= S_ERROR;
            r_upg_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_err     <= 1'b1;
          end
        end

        S_RELEASE: begin
          if (r_rel_cnt == RUN_RST_LAST) begin
            r_state   <= S_RUN;
            r_cpu_rst <= 1'b0;
          end else begin
            r_rel_cnt <= r_rel_cnt + RW'(1);
          end
        end

        S_ERROR: begin
          if (r_spg_s) begin
            r_state      <= S_ARM;
            r_origin_err <= 1'b1;
            r_hold_cnt   <= '0;
          end
        end

        default: begin
          r_state   <= S_RELEASE;
          r_rel_cnt <= '0;
          r_upg_rst <= 1'b1;
          r_cpu_rst <= 1'b1;
          r_busy    <= 1'b0;
          r_err     <= 1'b0;
        end
      endcase
    end
  end

  assign upg_rst_o    = r_upg_rst;
  assign cpu_rst_o    = r_cpu_rst;
  assign busy_o       = r_busy;
  assign err_o        = r_err;
  assign state_o      = r_state;
  assign imem_words_o = r_imem_words;
  assign dmem_words_o = r_dmem_words;

endmodule

// File: tb/tb_upg_boot_ctrl.sv
// Directed bench for upg_boot_ctrl with HOLD=4, TIMEOUT=64, RUN_RST=4; expected values
// are hand-derived from the documented edge-by-edge timing.
module tb_upg_boot_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_pg;
  logic        upg_wen_i;
  logic [14:0] upg_adr_i;
  logic        upg_done_i;
  logic        upg_rst_o;
  logic        cpu_rst_o;
  logic        imem_wen_o;
  logic        dmem_wen_o;
  logic [13:0] imem_words_o;
  logic [13:0] dmem_words_o;
  logic        busy_o;
  logic        err_o;
  logic [2:0]  state_o;

  int checks   = 0;
  int failures = 0;
  int imem_pulses = 0;
  int dmem_pulses = 0;

  upg_boot_ctrl #(
    .HOLD_CYCLES   (4),
    .TIMEOUT_CYCLES(64),
    .RUN_RST_CYCLES(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start_pg    (start_pg),
    .upg_wen_i   (upg_wen_i),
    .upg_adr_i   (upg_adr_i),
    .upg_done_i  (upg_done_i),
    .upg_rst_o   (upg_rst_o),
    .cpu_rst_o   (cpu_rst_o),
    .imem_wen_o  (imem_wen_o),
    .dmem_wen_o  (dmem_wen_o),
    .imem_words_o(imem_words_o),
    .dmem_words_o(dmem_words_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .state_o     (state_o)
  );

  always #5 clock = ~clock;

  // Pulse counters observe the gated enables exactly at the active edge.
  always @(posedge clock) begin
    if (imem_wen_o) imem_pulses <= imem_pulses + 1;
    if (dmem_wen_o) dmem_pulses <= dmem_pulses + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_pg = 1'b0;
    upg_wen_i = 1'b0;
    upg_adr_i = '0;
    upg_done_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (state_o !== 3'd3 || upg_rst_o !== 1'b1 || cpu_rst_o !== 1'b1 || busy_o !== 1'b0 ||
        err_o !== 1'b0 || imem_words_o !== 14'd0 || dmem_words_o !== 14'd0 || imem_wen_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: state=%0d upg_rst=%b cpu_rst=%b busy=%b err=%b iw=%0d dw=%0d wen=%b, want 3 1 1 0 0 0 0 0",
               state_o, upg_rst_o, cpu_rst_o, busy_o, err_o, imem_words_o, dmem_words_o, imem_wen_o);
    end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (cpu_rst_o !== (i < 4) || state_o !== ((i < 4) ? 3'd3 : 3'd0) || upg_rst_o !== 1'b1) begin
        failures++;
        $display("FAIL powerup_edge%0d: cpu_rst=%b state=%0d upg_rst=%b, want %b %0d 1",
                 i, cpu_rst_o, state_o, upg_rst_o, (i < 4), (i < 4) ? 3 : 0);
      end
    end
  endtask

  task automatic test_arm_abort();
    logic [2:0] exp_state [6] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd0};
    start_pg = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) start_pg = 1'b0;
      checks++;
      if (state_o !== exp_state[i] || upg_rst_o !== 1'b1 || cpu_rst_o !== 1'b0) begin
        failures++;
        $display("FAIL arm_abort_edge%0d: state=%0d upg_rst=%b cpu_rst=%b, want %0d 1 0",
                 i, state_o, upg_rst_o, cpu_rst_o, exp_state[i]);
      end
    end
    repeat (3) tick();
  endtask

  // Holds start_pg until LOAD; the state before ARM is the origin (RUN or ERROR).
  task automatic enter_load(input logic [2:0] origin);
    logic [2:0] exp;
    start_pg = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      exp = (i < 2) ? origin : ((i < 6) ? 3'd1 : 3'd2);
      checks++;
      if (state_o !== exp) begin
        failures++;
        $display("FAIL enter_load_edge%0d: state=%0d want %0d", i, state_o, exp);
      end
    end
    start_pg = 1'b0;
    checks++;
    if (upg_rst_o !== 1'b0 || cpu_rst_o !== 1'b1 || busy_o !== 1'b1 || err_o !== 1'b0 ||
        imem_words_o !== 14'd0 || dmem_words_o !== 14'd0) begin
      failures++;
      $display("FAIL load_entry: upg_rst=%b cpu_rst=%b busy=%b err=%b iw=%0d dw=%0d, want 0 1 1 0 0 0",
               upg_rst_o, cpu_rst_o, busy_o, err_o, imem_words_o, dmem_words_o);
    end
  endtask

  task automatic do_write(input logic [14:0] adr, input logic done, input logic exp_i, input logic exp_d);
    upg_wen_i = 1'b1;
    upg_adr_i = adr;
    upg_done_i = done;
    #1;
    checks++;
    if (imem_wen_o !== exp_i || dmem_wen_o !== exp_d) begin
      failures++;
      $display("FAIL wen_gate_%h: imem_wen=%b dmem_wen=%b, want %b %b", adr, imem_wen_o, dmem_wen_o, exp_i, exp_d);
    end
    tick();
    upg_wen_i = 1'b0;
    upg_done_i = 1'b0;
  endtask

  task automatic test_full_load();
    int base_i;
    int base_d;
    enter_load(3'd0);
    base_i = imem_pulses;
    base_d = dmem_pulses;
    do_write(15'h0000, 1'b1, 1'b1, 1'b0);
    checks++;
    if (state_o !== 3'd2) begin
      failures++;
      $display("FAIL first_cycle_done: state=%0d want 2", state_o);
    end
    for (int a = 1; a < 5; a++) do_write(15'(a), 1'b0, 1'b1, 1'b0);
    do_write(15'h4000, 1'b0, 1'b0, 1'b1);
    do_write(15'h4001, 1'b0, 1'b0, 1'b1);
    do_write(15'h4002, 1'b1, 1'b0, 1'b1);
    checks++;
    if (state_o !== 3'd3 || imem_words_o !== 14'd5 || dmem_words_o !== 14'd3 ||
        imem_pulses - base_i != 5 || dmem_pulses - base_d != 3 || busy_o !== 1'b0 ||
        upg_rst_o !== 1'b1 || cpu_rst_o !== 1'b1) begin
      failures++;
      $display("FAIL load_done: state=%0d iw=%0d dw=%0d ipulse=%0d dpulse=%0d busy=%b upg_rst=%b cpu_rst=%b, want 3 5 3 5 3 0 1 1",
               state_o, imem_words_o, dmem_words_o, imem_pulses - base_i, dmem_pulses - base_d,
               busy_o, upg_rst_o, cpu_rst_o);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (state_o !== ((i < 4) ? 3'd3 : 3'd0) || cpu_rst_o !== (i < 4)) begin
        failures++;
        $display("FAIL release_edge%0d: state=%0d cpu_rst=%b, want %0d %b", i, state_o, cpu_rst_o, (i < 4) ? 3 : 0, (i < 4));
      end
    end
    checks++;
    if (imem_words_o !== 14'd5 || dmem_words_o !== 14'd3) begin
      failures++;
      $display("FAIL words_hold: iw=%0d dw=%0d want 5 3", imem_words_o, dmem_words_o);
    end
  endtask

  task automatic test_timeout();
    enter_load(3'd0);
    do_write(15'h0005, 1'b0, 1'b1, 1'b0);
    repeat (63) tick();
    checks++;
    if (state_o !== 3'd2) begin
      failures++;
      $display("FAIL timeout_early: state=%0d want 2", state_o);
    end
    tick();
    checks++;
    if (state_o !== 3'd4 || err_o !== 1'b1 || cpu_rst_o !== 1'b1 || upg_rst_o !== 1'b1 ||
        busy_o !== 1'b0 || imem_words_o !== 14'd1) begin
      failures++;
      $display("FAIL timeout: state=%0d err=%b cpu_rst=%b upg_rst=%b busy=%b iw=%0d, want 4 1 1 1 0 1",
               state_o, err_o, cpu_rst_o, upg_rst_o, busy_o, imem_words_o);
    end
    enter_load(3'd4);
    tick();
    upg_done_i = 1'b1;
    tick();
    upg_done_i = 1'b0;
    checks++;
    if (state_o !== 3'd3 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reload_done: state=%0d err=%b want 3 0", state_o, err_o);
    end
    repeat (4) tick();
    checks++;
    if (state_o !== 3'd0) begin
      failures++;
      $display("FAIL reload_run: state=%0d want 0", state_o);
    end
  endtask

  task automatic test_saturate();
    enter_load(3'd0);
    upg_adr_i = 15'h0000;
    upg_wen_i = 1'b1;
    repeat (16390) tick();
    checks++;
    if (imem_words_o !== 14'd16383 || dmem_words_o !== 14'd0 || state_o !== 3'd2) begin
      failures++;
      $display("FAIL saturate: iw=%0d dw=%0d state=%0d want 16383 0 2", imem_words_o, dmem_words_o, state_o);
    end
  endtask

  task automatic test_reset_mid_load();
    reset = 1'b1;
    #1;
    checks++;
    if (imem_wen_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_gate: imem_wen=%b want 0", imem_wen_o);
    end
    tick();
    checks++;
    if (state_o !== 3'd3 || imem_words_o !== 14'd0 || dmem_words_o !== 14'd0 ||
        cpu_rst_o !== 1'b1 || upg_rst_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_load: state=%0d iw=%0d dw=%0d cpu_rst=%b upg_rst=%b busy=%b, want 3 0 0 1 1 0",
               state_o, imem_words_o, dmem_words_o, cpu_rst_o, upg_rst_o, busy_o);
    end
    reset = 1'b0;
    upg_wen_i = 1'b0;
    repeat (4) tick();
    checks++;
    if (state_o !== 3'd0 || cpu_rst_o !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_run: state=%0d cpu_rst=%b want 0 0", state_o, cpu_rst_o);
    end
  endtask

  initial begin
    test_reset();
    test_arm_abort();
    test_full_load();
    test_timeout();
    test_saturate();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
